// File: rtl/hilo_mdu_pkg.sv
// Shared encodings and sizes for the HI/LO multiply/divide unit.
package mdu_defs;

   localparam int MDU_WIDTH = 32;
   localparam int CNT_W     = 5;

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/hilo_div_core.sv
// Restoring divider datapath: one trial subtraction per step on unsigned magnitudes.
module hilo_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   assign shifted = {remainder, quotient[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr};

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remainder <= '0;
         quotient  <= '0;
         dvsr      <= '0;
      end else if (load) begin
         remainder <= '0;
         quotient  <= dividend;
         dvsr      <= divisor;
      end else if (step) begin
         // A zero divisor never borrows, giving all-ones quotient and remainder=dividend.
         if (!diff[WIDTH]) begin
            remainder <= diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= shifted[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit producing HI/LO write pulses and a stall request.
module hilo_mdu
   import mdu_defs::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stall_req,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_t             state, state_nx;
   op_t                op_c;
   logic [CNT_W-1:0]   count;
   logic               accept, acc_mul, acc_div, acc_mthi, acc_mtlo, is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH:0]     sum;
   logic               neg_res, neg_rem, is_div;
   logic               done_we, mt_hi, mt_lo;
   logic [WIDTH-1:0]   hi_q, lo_q, quotient, remainder, res_hi, res_lo;

   assign op_c      = op_t'(op);
   assign accept    = start && !flush && !rst && (state == ST_IDLE);
   assign acc_mul   = accept && (op_c == OP_MULT || op_c == OP_MULTU);
   assign acc_div   = accept && (op_c == OP_DIV  || op_c == OP_DIVU);
   assign acc_mthi  = accept && (op_c == OP_MTHI);
   assign acc_mtlo  = accept && (op_c == OP_MTLO);
   assign is_signed = (op_c == OP_MULT) || (op_c == OP_DIV);
   assign mag_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nx  = state;
      stall_req = 1'b0;
      done_we   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (acc_mul) begin
               state_nx  = ST_MUL;
               stall_req = 1'b1;
            end else if (acc_div) begin
               state_nx  = ST_DIV;
               stall_req = 1'b1;
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush) begin
               state_nx = ST_IDLE;
            end else begin
               stall_req = 1'b1;
               if (count == CNT_W'(ITER-1)) state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
            done_we  = !flush;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   hilo_div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (acc_div),
      .step      (state == ST_DIV),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
   assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         mcand   <= '0;
         prod    <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         is_div  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         mt_hi   <= 1'b0;
         mt_lo   <= 1'b0;
      end else begin
         mt_hi <= acc_mthi;
         mt_lo <= acc_mtlo;
         if (acc_mul || acc_div) begin
            count   <= '0;
            mcand   <= mag_a;
            prod    <= {{WIDTH{1'b0}}, mag_b};
            neg_res <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem <= is_signed && src_a[WIDTH-1];
            is_div  <= acc_div;
         end else if (state == ST_MUL || state == ST_DIV) begin
            count <= count + 1'b1;
         end
         if (state == ST_MUL) prod <= {sum, prod[WIDTH-1:1]};
         if (done_we) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end else begin
            if (acc_mthi) hi_q <= src_a;
            if (acc_mtlo) lo_q <= src_a;
         end
      end
   end

   assign prod_fix = neg_res ? -prod : prod;
   assign res_hi   = is_div ? (neg_rem ? -remainder : remainder) : prod_fix[2*WIDTH-1:WIDTH];
   assign res_lo   = is_div ? (neg_res ? -quotient : quotient) : prod_fix[WIDTH-1:0];

   assign hi_we = done_we || mt_hi;
   assign lo_we = done_we || mt_lo;
   assign hi_o  = done_we ? res_hi : hi_q;
   assign lo_o  = done_we ? res_lo : lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized self-checking bench for hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;
   import mdu_defs::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] src_a = '0, src_b = '0;
   logic        flush = 1'b0;
   logic        stall_req, hi_we, lo_we;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   hilo_mdu #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .stall_req(stall_req), .hi_we(hi_we), .lo_we(lo_we),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, b);
      longint sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         OP_MULT:  begin p = sa * sb; return p; end
         OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; return up; end
         OP_DIV: begin
            if (b == 0) return {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         OP_DIVU: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         default: return '0;
      endcase
   endfunction

   // Drives one iterative op from a negedge; optionally pokes a start while busy.
   task automatic do_iter(input string tag, input logic [2:0] o, input logic [31:0] a, b,
                          input bit poke);
      logic [63:0] exp;
      int stall_cnt, we_cnt;
      exp = ref_model(o, a, b);
      start = 1'b1; op = o; src_a = a; src_b = b;
      #1 check({tag, "_stall_c0"}, stall_req, 1);
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      stall_cnt = 0; we_cnt = 0;
      for (int c = 1; c <= 32; c++) begin
         if (stall_req) stall_cnt++;
         if (hi_we || lo_we) we_cnt++;
         if (poke && c == 5) begin
            start = 1'b1; op = OP_DIVU; src_a = 32'd1; src_b = 32'd1;
         end else begin
            start = 1'b0; op = OP_NONE;
         end
         @(negedge clk);
      end
      check({tag, "_stall_cycles"}, stall_cnt, 32);
      check({tag, "_early_we"}, we_cnt, 0);
      check({tag, "_done_ctl"}, {hi_we, lo_we, stall_req}, 3'b110);
      check({tag, "_result"}, {hi_o, lo_o}, exp);
      @(negedge clk);
      check({tag, "_we_after"}, {hi_we, lo_we}, 2'b00);
   endtask

   task automatic do_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
      start = 1'b1; op = o; src_a = a;
      #1 check({tag, "_stall"}, stall_req, 0);
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      check({tag, "_we"}, {hi_we, lo_we}, (o == OP_MTHI) ? 2'b10 : 2'b01);
      check({tag, "_data"}, (o == OP_MTHI) ? hi_o : lo_o, a);
      @(negedge clk);
      check({tag, "_we_after"}, {hi_we, lo_we}, 2'b00);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int quiet;
      logic [2:0] ro;
      #1;
      check("reset_out", {stall_req, hi_we, lo_we, hi_o, lo_o}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed arithmetic cases
      do_iter("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      do_iter("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7, 0);
      do_iter("divu_7_2",  OP_DIVU,  32'd7, 32'd2, 0);
      do_iter("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'd2, 0);
      do_iter("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0);
      do_iter("divu_z",    OP_DIVU,  32'd5, 32'd0, 0);
      do_iter("div_z_neg", OP_DIV,   32'hFFFFFFF9, 32'd0, 0);
      do_iter("div_z_pos", OP_DIV,   32'd9, 32'd0, 0);

      // MTHI followed immediately by MTLO
      start = 1'b1; op = OP_MTHI; src_a = 32'h12345678;
      #1 check("mthi_stall", stall_req, 0);
      @(negedge clk);
      op = OP_MTLO; src_a = 32'hCAFEBABE;
      check("mthi_we", {hi_we, lo_we, stall_req}, 3'b100);
      check("mthi_data", hi_o, 32'h12345678);
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      check("mtlo_we", {hi_we, lo_we, stall_req}, 3'b010);
      check("mtlo_data", lo_o, 32'hCAFEBABE);
      check("mtlo_hi_hold", hi_o, 32'h12345678);
      @(negedge clk);
      check("mt_we_after", {hi_we, lo_we}, 2'b00);

      // Flush mid-divide
      start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1 check("flush_stall", stall_req, 0);
      @(negedge clk);
      flush = 1'b0;
      quiet = 0;
      repeat (40) begin
         if (hi_we || lo_we || stall_req) quiet++;
         @(negedge clk);
      end
      check("flush_quiet", quiet, 0);
      do_iter("post_flush", OP_MULTU, 32'd3, 32'd4, 0);

      // Flush in the DONE cycle suppresses the pulse
      start = 1'b1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      repeat (32) @(negedge clk);
      flush = 1'b1;
      #1 check("done_flush_we", {hi_we, lo_we, stall_req}, 3'b000);
      check("done_flush_hold", {hi_o, lo_o}, {32'd0, 32'd12});
      @(negedge clk);
      flush = 1'b0;
      check("done_flush_after", {hi_we, lo_we}, 2'b00);

      // Flush coinciding with start is not accepted
      start = 1'b1; op = OP_MULT; src_a = 32'd2; src_b = 32'd2; flush = 1'b1;
      #1 check("flush_start_stall", stall_req, 0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0; op = OP_NONE;
      check("flush_start_idle", stall_req, 0);

      // Asynchronous reset mid-multiply
      start = 1'b1; op = OP_MULTU; src_a = 32'h0000FFFF; src_b = 32'h0000FFFF;
      @(negedge clk);
      start = 1'b0; op = OP_NONE;
      repeat (14) @(negedge clk);
      #2 rst = 1'b1;
      #1 check("async_rst_out", {stall_req, hi_we, lo_we, hi_o, lo_o}, '0);
      @(negedge clk);
      rst = 1'b0;
      quiet = 0;
      repeat (40) begin
         if (hi_we || lo_we || stall_req) quiet++;
         @(negedge clk);
      end
      check("rst_quiet", quiet, 0);
      do_iter("busy_poke", OP_MULT, 32'hFFFF0001, 32'h00012345, 1);

      // Randomized mix, issued back-to-back
      repeat (30) begin
         ro = 3'($urandom_range(1, 6));
         if (ro == OP_MTHI || ro == OP_MTLO) do_mt("rand_mt", ro, $urandom);
         else do_iter("rand", ro, pick(), pick(), bit'($urandom_range(0, 1)));
      end

      // NONE and reserved ops are ignored
      start = 1'b1; op = OP_RSVD;
      #1 check("rsvd_stall", stall_req, 0);
      @(negedge clk);
      op = OP_NONE;
      check("rsvd_we", {hi_we, lo_we, stall_req}, 3'b000);
      @(negedge clk);
      start = 1'b0;
      check("none_we", {hi_we, lo_we, stall_req}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
